// File: rtl/faerie_addr_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | faerie_addr_unit : PC/AR/IR state, memory address mux and bus stall gate   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module faerie_addr_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  ZP_PAGE   = 8'h00,
  parameter bit          SYNC_READ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic        pc_addr,
  input  logic        zp_addr,
  input  logic        set_al,
  input  logic        set_ah,
  input  logic        inc_al,
  input  logic        reset_b,
  input  logic        branch,
  input  logic        cond,
  input  logic [7:0]  rdata,
  input  logic        mem_ready,
  output logic [15:0] addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic        advance,
  output logic [7:0]  insn,
  output logic [15:0] pc,
  output logic [15:0] ar
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  al_q, al_d;
  logic [7:0]  ah_q, ah_d;
  logic [7:0]  ir_q, ir_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  now_flags;
  logic [2:0]  cap_flags;
  logic        access;

  always_comb begin
    access  = re | we;
    advance = ~access | mem_ready;
    mem_we  = we;
    mem_re  = re & ~we;
    if (pc_addr) begin
      addr = pc_q;
    end else if (zp_addr) begin
      addr = {ZP_PAGE, al_q};
    end else begin
      addr = {ah_q, al_q};
    end
  end

  // Capture flags are {AL, AH, IR}; in sync mode they act one accepted cycle late.
  always_comb begin
    now_flags = {set_al, set_ah, reset_b & re};
    cap_flags = SYNC_READ ? pend_q : now_flags;
    pc_d      = pc_q;
    al_d      = al_q;
    ah_d      = ah_q;
    ir_d      = ir_q;
    pend_d    = pend_q;
    if (advance) begin
      pend_d = SYNC_READ ? now_flags : 3'b000;
      if (branch && cond) begin
        pc_d = {ah_q, al_q};
      end else if (access && pc_addr) begin
        pc_d = pc_q + 16'd1;
      end
      if (cap_flags[2]) begin
        al_d = rdata;
      end else if (inc_al) begin
        al_d = al_q + 8'd1;
      end
      if (cap_flags[1]) begin
        ah_d = rdata;
      end
      if (cap_flags[0]) begin
        ir_d = rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      al_q   <= 8'h00;
      ah_q   <= 8'h00;
      ir_q   <= 8'h00;
      pend_q <= 3'b000;
    end else begin
      pc_q   <= pc_d;
      al_q   <= al_d;
      ah_q   <= ah_d;
      ir_q   <= ir_d;
      pend_q <= pend_d;
    end
  end

  assign insn = ir_q;
  assign pc   = pc_q;
  assign ar   = {ah_q, al_q};

endmodule
`default_nettype wire

// File: tb/tb_faerie_addr_unit.sv
`default_nettype none
// Directed bench for faerie_addr_unit: a SYNC_READ=1 and a SYNC_READ=0 instance
// share one stimulus stream; expectations go through a FIFO scoreboard.
module tb_faerie_addr_unit;

  logic        clk;
  logic        rst_n;
  logic        re, we, pc_addr, zp_addr, set_al, set_ah, inc_al, reset_b;
  logic        branch, cond, mem_ready;
  logic [7:0]  rdata;

  logic [15:0] addr1, pc1, ar1;
  logic        mem_re1, mem_we1, advance1;
  logic [7:0]  insn1;
  logic [15:0] addr0, pc0, ar0;
  logic        mem_re0, mem_we0, advance0;
  logic [7:0]  insn0;

  faerie_addr_unit #(.RESET_PC(16'h0100), .ZP_PAGE(8'h00), .SYNC_READ(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .pc_addr(pc_addr), .zp_addr(zp_addr),
    .set_al(set_al), .set_ah(set_ah), .inc_al(inc_al), .reset_b(reset_b),
    .branch(branch), .cond(cond), .rdata(rdata), .mem_ready(mem_ready),
    .addr(addr1), .mem_re(mem_re1), .mem_we(mem_we1), .advance(advance1),
    .insn(insn1), .pc(pc1), .ar(ar1)
  );

  faerie_addr_unit #(.RESET_PC(16'h0100), .ZP_PAGE(8'h00), .SYNC_READ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .pc_addr(pc_addr), .zp_addr(zp_addr),
    .set_al(set_al), .set_ah(set_ah), .inc_al(inc_al), .reset_b(reset_b),
    .branch(branch), .cond(cond), .rdata(rdata), .mem_ready(mem_ready),
    .addr(addr0), .mem_re(mem_re0), .mem_we(mem_we0), .advance(advance0),
    .insn(insn0), .pc(pc0), .ar(ar0)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [15:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; re = 0; we = 0; pc_addr = 0; zp_addr = 0; set_al = 0; set_ah = 0;
    inc_al = 0; reset_b = 0; branch = 0; cond = 0; mem_ready = 1; rdata = 8'h00;

    // asynchronous reset in the middle of a cycle
    #2;
    pc_addr = 1; re = 1; rst_n = 0;
    push("rst_addr", 16'h0100); push("rst_pc", 16'h0100);
    push("rst_ar", 16'h0000);   push("rst_insn", 16'h0000);
    #1;
    chk(addr1); chk(pc1); chk(ar1); chk({8'h00, insn1});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; reset_b = 1; rdata = 8'h00;

    // fetch run: opcode bytes arrive one accepted cycle after their address
    tick(); push("fetch_pc1", 16'h0101); chk(pc1);
    rdata = 8'h12;
    tick(); push("fetch_pc2", 16'h0102); chk(pc1); push("fetch_ir1", 16'h0012); chk({8'h00, insn1});
    rdata = 8'h34;
    tick(); push("fetch_pc3", 16'h0103); chk(pc1); push("fetch_ir2", 16'h0034); chk({8'h00, insn1});
    pc_addr = 0; re = 0; reset_b = 0; rdata = 8'h56;
    tick(); push("fetch_ir3", 16'h0056); chk({8'h00, insn1}); push("fetch_pc_hold", 16'h0103); chk(pc1);

    // stall with an opcode capture pending
    pc_addr = 1; re = 1; reset_b = 1; rdata = 8'h00;
    tick(); push("prestall_pc", 16'h0104); chk(pc1);
    mem_ready = 0; rdata = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      #1; push("stall_adv", 16'h0000); chk({15'h0, advance1});
      tick();
      push("stall_pc", 16'h0104); chk(pc1);
      push("stall_ir", 16'h0056); chk({8'h00, insn1});
    end
    mem_ready = 1;
    #1; push("release_adv", 16'h0001); chk({15'h0, advance1});
    tick(); push("release_pc", 16'h0105); chk(pc1); push("release_ir", 16'h00A5); chk({8'h00, insn1});
    pc_addr = 0; re = 0; reset_b = 0; rdata = 8'hC3;
    tick(); push("tail_ir", 16'h00C3); chk({8'h00, insn1});

    // AR = 0x20FF, then zero-page pointer walk
    set_ah = 1;
    tick(); set_ah = 0; set_al = 1; rdata = 8'h20;
    tick(); set_al = 0; rdata = 8'hFF;
    tick(); push("ar_20ff", 16'h20FF); chk(ar1);
    zp_addr = 1; inc_al = 1; re = 1;
    #1; push("zp_addr", 16'h00FF); chk(addr1); push("zp_mem_re", 16'h0001); chk({15'h0, mem_re1});
    tick(); push("zp_inc_wrap", 16'h2000); chk(ar1);
    inc_al = 0; set_al = 1;
    tick(); set_al = 0; inc_al = 1; rdata = 8'h77;
    tick(); push("load_beats_inc", 16'h2077); chk(ar1);
    rdata = 8'h00;
    tick(); push("inc_only", 16'h2078); chk(ar1);
    inc_al = 0; zp_addr = 0; re = 0;

    // branch taken / not taken
    set_ah = 1;
    tick(); set_ah = 0; set_al = 1; rdata = 8'hBE;
    tick(); set_al = 0; rdata = 8'hEF;
    tick(); push("ar_beef", 16'hBEEF); chk(ar1);
    branch = 1; cond = 1;
    tick(); push("br_taken", 16'hBEEF); chk(pc1);
    cond = 0;
    tick(); push("br_not_taken", 16'hBEEF); chk(pc1);
    pc_addr = 1; re = 1;
    tick(); push("br_nt_fetch", 16'hBEF0); chk(pc1);
    pc_addr = 0; re = 0; branch = 0;

    // branch overrides increment, then PC wrap
    set_ah = 1;
    tick(); set_ah = 0; set_al = 1; rdata = 8'hFF;
    tick(); set_al = 0; rdata = 8'hFF;
    tick(); push("ar_ffff", 16'hFFFF); chk(ar1);
    branch = 1; cond = 1; pc_addr = 1; re = 1;
    tick(); push("br_over_inc", 16'hFFFF); chk(pc1);
    branch = 0; cond = 0;
    tick(); push("pc_wrap", 16'h0000); chk(pc1);
    pc_addr = 0; re = 0;

    // reset with an AL capture pending discards it
    set_al = 1; rdata = 8'h00;
    tick(); set_al = 0;
    #1; rst_n = 0; pc_addr = 1; re = 1;
    #1; push("rst2_addr", 16'h0100); chk(addr1);
    tick(); tick();
    rst_n = 1;
    #1; push("post_rst_addr", 16'h0100); chk(addr1);
    pc_addr = 0; re = 0; set_al = 1; rdata = 8'h40;
    tick();
    push("sync0_al_load", 16'h0040); chk(ar0);
    push("pend_discarded", 16'h0000); chk(ar1);

    // write priority on the same-cycle capture instance
    set_al = 0; re = 1; we = 1; zp_addr = 1; set_ah = 1; rdata = 8'h7A;
    #1;
    push("wp_mem_we", 16'h0001); chk({15'h0, mem_we0});
    push("wp_mem_re", 16'h0000); chk({15'h0, mem_re0});
    push("wp_addr", 16'h0040);   chk(addr0);
    tick();
    push("sync0_ah_load", 16'h7A40); chk(ar0);
    push("sync1_al_late", 16'h007A); chk(ar1);
    re = 0; we = 0; zp_addr = 0; set_ah = 0; rdata = 8'h11;
    tick();
    push("sync1_ah_late", 16'h117A); chk(ar1);
    push("sync0_ah_hold", 16'h7A40); chk(ar0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
